// File: rtl/danmaku_frame_reader_if.sv
// Bundles the Avalon-MM burst read port and the 64-bit stream port of the danmaku frame reader.
// The master modport is the reader's view; the slave modport is the memory/adapter side.
interface danmaku_frame_reader_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [6:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [63:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic [63:0]       data_src;
    logic              valid_src;
    logic              ready_src;

    modport master (
        output avm_address, avm_read, avm_burstcount, data_src, valid_src,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid, ready_src
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount, data_src, valid_src,
        output avm_waitrequest, avm_readdata, avm_readdatavalid, ready_src
    );
endinterface

// File: rtl/danmaku_frame_reader.sv
// Fetches one packed overlay frame from SDRAM with Avalon-MM bursts and replays it as a 64-bit stream.
// Read returns land in a local FIFO; a burst is only issued when the FIFO can absorb all of it.
module danmaku_frame_reader #(
    parameter int ADDR_W      = 32,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_WORDS = 19200,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      frame_base,
    input  logic                   frame_start,
    output logic                   busy,
    danmaku_frame_reader_if.master bus
);

    localparam int REM_W = ($clog2(FRAME_WORDS + 1) < 8) ? 8 : $clog2(FRAME_WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [REM_W-1:0]  remaining_q;
    logic [6:0]        beats_left_q;
    logic              pending_q;
    logic [ADDR_W-1:0] pending_base_q;
    logic              busy_q;
    logic              avm_read_q;
    logic [ADDR_W-1:0] avm_address_q;
    logic [6:0]        avm_burstcount_q;

    logic [63:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  fifo_count_q;
    logic              valid_q;
    logic [63:0]       data_q;

    logic [6:0]        burst_s;
    logic              credit_ok_s;
    logic              fifo_wr_s;
    logic              fifo_rd_s;
    logic              drain_done_s;
    logic              restart_s;
    logic [ADDR_W-1:0] restart_base_s;

    // Burst sizing, FIFO credit and handshake decode
    always_comb begin
        burst_s        = 7'd0;
        credit_ok_s    = 1'b0;
        fifo_wr_s      = 1'b0;
        fifo_rd_s      = 1'b0;
        drain_done_s   = 1'b0;
        restart_s      = 1'b0;
        restart_base_s = pending_base_q;
        if (remaining_q >= REM_W'(BURST_LEN)) begin
            burst_s = 7'(BURST_LEN);
        end else begin
            burst_s = remaining_q[6:0];
        end
        credit_ok_s  = (16'(fifo_count_q) + 16'(burst_s)) <= 16'(FIFO_DEPTH);
        fifo_wr_s    = (state_q == S_WAIT) && bus.avm_readdatavalid;
        fifo_rd_s    = (fifo_count_q != CNT_W'(0)) && (!valid_q || bus.ready_src);
        drain_done_s = (fifo_count_q == CNT_W'(0)) && !valid_q;
        restart_s    = pending_q || frame_start;
        // A start arriving in the same cycle is newer than anything already pending
        if (frame_start) begin
            restart_base_s = frame_base;
        end else begin
            restart_base_s = pending_base_q;
        end
    end

    // Frame sequencing FSM with registered Avalon request and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            addr_q           <= {ADDR_W{1'b0}};
            remaining_q      <= {REM_W{1'b0}};
            beats_left_q     <= 7'd0;
            pending_q        <= 1'b0;
            pending_base_q   <= {ADDR_W{1'b0}};
            busy_q           <= 1'b0;
            avm_read_q       <= 1'b0;
            avm_address_q    <= {ADDR_W{1'b0}};
            avm_burstcount_q <= 7'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        addr_q      <= frame_base;
                        remaining_q <= REM_W'(FRAME_WORDS);
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!avm_read_q) begin
                        if (credit_ok_s) begin
                            avm_read_q       <= 1'b1;
                            avm_address_q    <= addr_q;
                            avm_burstcount_q <= burst_s;
                        end
                    end else if (!bus.avm_waitrequest) begin
                        avm_read_q   <= 1'b0;
                        beats_left_q <= avm_burstcount_q;
                        addr_q       <= addr_q + ADDR_W'({avm_burstcount_q, 3'b000});
                        remaining_q  <= remaining_q - REM_W'(avm_burstcount_q);
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.avm_readdatavalid) begin
                        beats_left_q <= beats_left_q - 7'd1;
                        if (beats_left_q == 7'd1) begin
                            state_q <= (remaining_q != {REM_W{1'b0}}) ? S_ISSUE : S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done_s) begin
                        if (restart_s) begin
                            addr_q      <= restart_base_s;
                            remaining_q <= REM_W'(FRAME_WORDS);
                            pending_q   <= 1'b0;
                            state_q     <= S_ISSUE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (frame_start && (state_q != S_IDLE) && !((state_q == S_DRAIN) && drain_done_s)) begin
                pending_q      <= 1'b1;
                pending_base_q <= frame_base;
            end
        end
    end

    // Return buffer storage; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            mem_q[wr_ptr_q] <= bus.avm_readdata;
        end
    end

    // FIFO pointers plus the registered show-ahead output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            fifo_count_q <= {CNT_W{1'b0}};
            valid_q      <= 1'b0;
            data_q       <= 64'd0;
        end else begin
            if (fifo_wr_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_rd_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                data_q   <= mem_q[rd_ptr_q];
                valid_q  <= 1'b1;
            end else if (bus.ready_src) begin
                valid_q <= 1'b0;
            end
            case ({fifo_wr_s, fifo_rd_s})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    assign busy               = busy_q;
    assign bus.avm_read       = avm_read_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_burstcount = avm_burstcount_q;
    assign bus.data_src       = data_q;
    assign bus.valid_src      = valid_q;

endmodule

// File: doc/danmaku_frame_reader.md
Name: danmaku_frame_reader

Overview:
- Avalon-MM burst read master that fetches the packed 4-bit-per-pixel danmaku overlay frame from SDRAM.
- Delivers the frame as a stream of 64-bit words into the pixel adapter's write side.
- Stream output connects to the adapter's data_src/valid_src/ready_src, in the adapter's clk_src domain.
- Buffers read returns internally because readdatavalid cannot be back-pressured.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- BURST_LEN, 16, maximum burstcount per read, power of 2, 1..64.
- FRAME_WORDS, 19200, 64-bit words per frame (640x480x4 bit / 64).
- FIFO_DEPTH, 64, internal buffer depth, power of 2, >= BURST_LEN.

Ports:
- clk  input  1  single clock; the same clock drives the adapter's clk_src.
- rst_n  input  1  asynchronous active-low reset.
- frame_base  input  ADDR_W  byte address of frame; 8-byte aligned; sampled on frame_start.
- frame_start  input  1  one-cycle pulse (vsync-derived) requesting a frame fetch.
- busy  output  1  high from accepted start until the last word leaves the stream output.
- avm_address  output  ADDR_W  burst start byte address.
- avm_read  output  1  read request.
- avm_burstcount  output  7  words in burst.
- avm_waitrequest  input  1  slave stall.
- avm_readdata  input  64  returned data.
- avm_readdatavalid  input  1  return strobe.
- data_src  output  64  stream data to the adapter.
- valid_src  output  1  stream valid.
- ready_src  input  1  adapter not full.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - busy, avm_read, valid_src = 0; avm_address, avm_burstcount = 0.
  - FIFO emptied; state IDLE; pending flag cleared.
- State machine IDLE -> ISSUE -> WAIT -> (ISSUE | DRAIN) -> IDLE.
- IDLE:
  - On frame_start, latch frame_base into addr and FRAME_WORDS into remaining.
  - busy=1 next cycle; go to ISSUE.
- ISSUE (request not yet asserted):
  - burst = min(BURST_LEN, remaining).
  - Assert avm_read, avm_address=addr, avm_burstcount=burst only when fifo_count + burst <= FIFO_DEPTH. Otherwise wait with avm_read=0.
  - Once asserted, avm_read/address/burstcount hold stable while avm_waitrequest=1.
  - On the cycle avm_read=1 and avm_waitrequest=0: go to WAIT, beats_left=burst, addr += 8*burst, remaining -= burst.
- WAIT:
  - Each cycle with avm_readdatavalid=1 writes avm_readdata into the FIFO and decrements beats_left.
  - readdatavalid outside WAIT is ignored.
  - Exactly one burst is outstanding at any time.
  - When the final beat arrives: go to ISSUE if remaining>0, else DRAIN.
- DRAIN: when the FIFO is empty and no word is on the output, busy=0 and go to IDLE.
- Stream output:
  - Registered showahead: data_src/valid_src come from the FIFO head.
  - A word transfers on valid_src & ready_src.
  - While valid_src=1 & ready_src=0, data_src holds stable.
  - First-word latency: valid_src rises no later than 2 cycles after the first readdatavalid of a frame.
  - Simultaneous FIFO write and read in one cycle: count unchanged, both honoured.
  - Throughput: 1 word/cycle when ready_src stays high.
- FIFO full can never occur with a write pending (guaranteed by the ISSUE credit check). Overflow is a design error; verification asserts it never happens.
- frame_start while busy: sets pending and latches frame_base into pending_base. The current frame completes untouched. On DRAIN->IDLE with pending set, start the new frame directly (busy stays 1). Further starts overwrite pending_base.
- frame_start in the same cycle as DRAIN->IDLE: treated as pending, same result.
- Word order is strictly memory order; no byte swapping (the adapter performs it).
- Short last burst: when FRAME_WORDS is not a multiple of BURST_LEN, the final burstcount equals the residue.
- avm_burstcount is never 0 while avm_read=1.

Test Plan:
- Reset, frame_base=0x1000, FRAME_WORDS=40, BURST_LEN=16, ready_src=1, zero-wait slave -> bursts at 0x1000/16, 0x1080/16, 0x1100/8. 40 words out in address order. busy falls after the 40th transfer.
- avm_waitrequest held high 5 cycles on the first burst -> avm_read/address/burstcount stable for all 5 cycles; single acceptance; no duplicate burst.
- ready_src=0 for 200 cycles mid-frame, FIFO_DEPTH=64 -> no new burst once fifo_count>48; no overflow; data_src stable; all words delivered intact after release.
- frame_start pulsed again at word 10 with base 0x8000 -> first frame completes 40 words. Second frame's first burst targets 0x8000 immediately after; busy never drops.
- Assert rst_n low mid-burst (WAIT, beats_left=7) -> all outputs 0 asynchronously. After release, stale readdatavalid ignored in IDLE. A new frame_start fetches a full frame correctly.
- FRAME_WORDS=1, BURST_LEN=16 -> single burst of count 1; one word out; busy high for that transfer only.
